func_sweep_ctrl: RTL and testbench
==================================

# func_sweep_ctrl

Exhaustive test sequencer for the 7-input gate-level logic function block (`y = a&b&c | ~d | ~e&f&g`). It drives all 128 input vectors in order onto the external function instance and waits a programmable settle time per vector. It compares the sampled output against an internal golden model and reports the mismatch count, the first failing vector and the count of ones. It sits between a bench/top-level start control and one instance of the function block.

## Interface
- `SETTLE`, default 1: cycles `vec` is held before `dut_y` is sampled. Legal range 1..15.
- `clk` input 1: single clock; all state updates on rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: begin a sweep. Sampled only in IDLE.
- `abort` input 1: cancel a running sweep.
- `dut_y` input 1: output of the function instance under test.
- `vec` output 7: stimulus to the function instance. Mapping: `vec[6]=a`, `vec[5]=b`, `vec[4]=c`, `vec[3]=d`, `vec[2]=e`, `vec[1]=f`, `vec[0]=g`.
- `busy` output 1: high while a sweep is running (states WAIT/SAMPLE).
- `done` output 1: one-cycle pulse when a sweep completes normally.
- `pass` output 1: high after a completed sweep with `err_cnt==0`.
- `err_cnt` output 8: number of mismatching vectors, 0..128.
- `first_err` output 7: first mismatching vector.
- `first_err_valid` output 1: `first_err` holds a captured vector.
- `ones_cnt` output 8: number of vectors where `dut_y==1`, 0..128.

## Operation
- States: IDLE, WAIT, SAMPLE, DONE. Reset state is IDLE.
- Reset values (async, while `rst_n==0`): every output is 0, the settle counter is 0 and the state is IDLE.
- **IDLE:**
  - `start==1` → WAIT.
  - On that transition: `vec`←0; `err_cnt`, `ones_cnt`, `first_err`, `first_err_valid` and `pass` are all cleared; settle counter←SETTLE−1.
  - Otherwise all outputs hold, so results persist until the next start.
- **WAIT:** settle counter decrements each cycle. When the counter is 0, go to SAMPLE. `vec` is stable throughout.
- **SAMPLE:** one cycle. Compare `dut_y` against the golden value `g = (vec[6]&vec[5]&vec[4]) | ~vec[3] | (~vec[2]&vec[1]&vec[0])`.
  - If `dut_y != g`: `err_cnt`+1.
  - If `dut_y != g` and `first_err_valid==0`: `first_err`←`vec` and `first_err_valid`←1.
  - If `dut_y==1`: `ones_cnt`+1.
  - If `vec==127` → DONE, and `vec` holds 127.
  - Otherwise `vec`+1, reload the settle counter to SETTLE−1, and go to WAIT.
- **DONE:** one cycle. `done`=1; `pass`←(`err_cnt==0`); next state IDLE.
- **Abort:**
  - `abort==1` in WAIT or SAMPLE → IDLE on the next edge.
  - The SAMPLE-cycle update is suppressed if abort is asserted in that same cycle.
  - `done` is not pulsed and `pass` stays 0. Partial counts and `vec` hold.
- **Priority:** abort > sample update. `start` is ignored outside IDLE. `start` and `abort` together in IDLE: start wins, because abort has no effect in IDLE.
- **Counter widths:** `err_cnt` and `ones_cnt` are 8 bits. Max value is 128, so no overflow and no saturation logic is needed.
- `vec` increments modulo 128, but the wrap from 127 never occurs because 127 terminates the sweep.

## Timing
- `start` sampled at edge T0: `vec`=0 and `busy`=1 from T0.
- Each vector occupies SETTLE+1 cycles: SETTLE cycles in WAIT, then 1 in SAMPLE.
- `dut_y` is sampled in the last cycle of each vector, so the external function has ≥SETTLE cycles to settle combinationally.
- The last SAMPLE ends at T0+128·(SETTLE+1). The `done` pulse is in the following cycle, and `busy` falls with the entry to DONE.
- Start-to-done latency: 128·(SETTLE+1)+1 cycles. With SETTLE=1 this is 257.
- Back-to-back sweeps: `start` may be asserted in the IDLE cycle right after DONE.
- Reset asserted mid-sweep clears everything immediately, without waiting for a clock edge.

## Test plan
- Correct function instance, SETTLE=1, pulse `start` → `done` 257 cycles later; `pass`=1, `err_cnt`=0, `ones_cnt`=79, `first_err_valid`=0.
- `dut_y` tied 0 → `err_cnt`=79, `ones_cnt`=0, `first_err`=0, `first_err_valid`=1, `pass`=0.
- `dut_y` tied 1 → `err_cnt`=49, `ones_cnt`=128, `first_err`=8 (`7'b0001000`), `pass`=0.
- SETTLE=3, correct instance → each `vec` value is held exactly 4 cycles; `done` arrives 513 cycles after start; results match the first scenario.
- Abort on the 10th SAMPLE cycle, then restart → no `done` pulse and `busy` drops the next cycle; the restarted sweep clears the counters and completes with `ones_cnt`=79.
- Assert `rst_n`=0 asynchronously mid-WAIT, plus `start` pulses while `busy` → all outputs go to 0 immediately; `start` pulses during `busy` do not restart or perturb `vec`.

Source files
------------

// File: rtl/func_sweep_ctrl.sv
// func_sweep_ctrl: exhaustive sequencer for the 7-input function
// y = a&b&c | ~d | ~e&f&g.
// It steps vec through 0..127. Each value is held for SETTLE cycles, then
// the external dut_y is sampled. The sample is checked against a golden
// model. Mismatch count, first failing vector and ones count are collected.
module func_sweep_ctrl #(
   parameter int unsigned SETTLE = 1   // hold cycles per vector, 1..15
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       abort,
   input  logic       dut_y,
   output logic [6:0] vec,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [7:0] err_cnt,
   output logic [6:0] first_err,
   output logic       first_err_valid,
   output logic [7:0] ones_cnt
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_WAIT   = 2'd1,
      S_SAMPLE = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   // Settle counter reload value: the counter runs SETTLE-1 down to 0.
   localparam logic [3:0] RELOAD = 4'(SETTLE - 1);

   state_t     state_q, state_d;
   logic [6:0] vec_q, vec_d;
   logic [3:0] cnt_q, cnt_d;
   logic [7:0] err_q, err_d;
   logic [7:0] ones_q, ones_d;
   logic [6:0] ferr_q, ferr_d;
   logic       fev_q, fev_d;
   logic       pass_q, pass_d;

   logic       golden;
   logic       mismatch;

   // Golden value of the function for the vector currently driven.
   assign golden   = (vec_q[6] & vec_q[5] & vec_q[4]) | ~vec_q[3]
                   | (~vec_q[2] & vec_q[1] & vec_q[0]);
   assign mismatch = (dut_y != golden);

   // State and result registers; reset clears everything immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         vec_q   <= '0;
         cnt_q   <= '0;
         err_q   <= '0;
         ones_q  <= '0;
         ferr_q  <= '0;
         fev_q   <= 1'b0;
         pass_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         vec_q   <= vec_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         ones_q  <= ones_d;
         ferr_q  <= ferr_d;
         fev_q   <= fev_d;
         pass_q  <= pass_d;
      end
   end

   // Next-state logic. Abort has priority over the sample update.
   always_comb begin
      state_d = state_q;
      vec_d   = vec_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      ones_d  = ones_q;
      ferr_d  = ferr_q;
      fev_d   = fev_q;
      pass_d  = pass_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_WAIT;
               vec_d   = '0;
               cnt_d   = RELOAD;
               err_d   = '0;
               ones_d  = '0;
               ferr_d  = '0;
               fev_d   = 1'b0;
               pass_d  = 1'b0;
            end
         end
         S_WAIT: begin
            if (abort) begin
               state_d = S_IDLE;
            end else if (cnt_q == 4'd0) begin
               state_d = S_SAMPLE;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_SAMPLE: begin
            if (abort) begin
               state_d = S_IDLE;
            end else begin
               if (mismatch) begin
                  err_d = err_q + 8'd1;
                  if (!fev_q) begin
                     ferr_d = vec_q;
                     fev_d  = 1'b1;
                  end
               end
               if (dut_y) begin
                  ones_d = ones_q + 8'd1;
               end
               if (vec_q == 7'd127) begin
                  state_d = S_DONE;
               end else begin
                  vec_d   = vec_q + 7'd1;
                  cnt_d   = RELOAD;
                  state_d = S_WAIT;
               end
            end
         end
         S_DONE: begin
            pass_d  = (err_q == 8'd0);
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign vec             = vec_q;
   assign busy            = (state_q == S_WAIT) || (state_q == S_SAMPLE);
   assign done            = (state_q == S_DONE);
   assign pass            = pass_q;
   assign err_cnt         = err_q;
   assign first_err       = ferr_q;
   assign first_err_valid = fev_q;
   assign ones_cnt        = ones_q;

endmodule

// File: tb/tb_func_sweep_ctrl.sv
// Testbench for func_sweep_ctrl. Two instances are used: SETTLE=1 and
// SETTLE=3. Each instance drives a function model that can inject faults
// per vector through a flip mask.
module tb_func_sweep_ctrl;

   logic       clk;
   logic       rst_n;
   logic       start_r [2];
   logic       abort_r [2];
   logic       dut_y_w [2];
   logic [6:0] vec_w   [2];
   logic       busy_w  [2];
   logic       done_w  [2];
   logic       pass_w  [2];
   logic [7:0] err_w   [2];
   logic [6:0] ferr_w  [2];
   logic       fev_w   [2];
   logic [7:0] ones_w  [2];
   logic [127:0] flip  [2];

   int tests = 0;
   int fails = 0;

   // Reference function computed from the boolean terms a..g.
   function automatic logic gold(input logic [6:0] v);
      int a, b, c, d, e, f, g;
      a = (int'(v) >> 6) & 1; b = (int'(v) >> 5) & 1; c = (int'(v) >> 4) & 1;
      d = (int'(v) >> 3) & 1; e = (int'(v) >> 2) & 1; f = (int'(v) >> 1) & 1;
      g = int'(v) & 1;
      return ((a == 1 && b == 1 && c == 1) || d == 0 || (e == 0 && f == 1 && g == 1)) ? 1'b1 : 1'b0;
   endfunction

   assign dut_y_w[0] = gold(vec_w[0]) ^ flip[0][vec_w[0]];
   assign dut_y_w[1] = gold(vec_w[1]) ^ flip[1][vec_w[1]];

   func_sweep_ctrl #(.SETTLE(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .start(start_r[0]), .abort(abort_r[0]),
      .dut_y(dut_y_w[0]), .vec(vec_w[0]), .busy(busy_w[0]), .done(done_w[0]),
      .pass(pass_w[0]), .err_cnt(err_w[0]), .first_err(ferr_w[0]),
      .first_err_valid(fev_w[0]), .ones_cnt(ones_w[0])
   );

   func_sweep_ctrl #(.SETTLE(3)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .start(start_r[1]), .abort(abort_r[1]),
      .dut_y(dut_y_w[1]), .vec(vec_w[1]), .busy(busy_w[1]), .done(done_w[1]),
      .pass(pass_w[1]), .err_cnt(err_w[1]), .first_err(ferr_w[1]),
      .first_err_valid(fev_w[1]), .ones_cnt(ones_w[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected results over vectors 0..last_v, given the flip mask of an instance.
   task automatic expect_range(input int inst, input int last_v, output int e_err,
                               output int e_ones, output int e_first, output bit e_fev);
      logic [6:0] v;
      logic       y;
      e_err = 0; e_ones = 0; e_first = 0; e_fev = 0;
      for (int i = 0; i <= last_v; i++) begin
         v = 7'(i);
         y = gold(v) ^ flip[inst][i];
         if (y != gold(v)) begin
            e_err++;
            if (!e_fev) begin e_first = i; e_fev = 1; end
         end
         if (y) e_ones++;
      end
   endtask

   task automatic test_reset();
      for (int k = 0; k < 2; k++) begin
         tests++;
         if (vec_w[k] !== 0 || busy_w[k] !== 0 || done_w[k] !== 0 || pass_w[k] !== 0 ||
             err_w[k] !== 0 || ferr_w[k] !== 0 || fev_w[k] !== 0 || ones_w[k] !== 0) begin
            fails++;
            $display("FAIL reset_inst%0d: vec=%0d busy=%b done=%b pass=%b err=%0d ferr=%0d fev=%b ones=%0d, all required 0",
                     k, vec_w[k], busy_w[k], done_w[k], pass_w[k], err_w[k], ferr_w[k], fev_w[k], ones_w[k]);
         end
      end
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      tests++;
      if (busy_w[0] !== 0 || busy_w[1] !== 0 || vec_w[0] !== 0) begin
         fails++;
         $display("FAIL idle_after_reset: busy0=%b busy1=%b vec0=%0d, required 0 0 0", busy_w[0], busy_w[1], vec_w[0]);
      end
      $display("[TB] reset checked");
   endtask

   // Full sweep: start, latency, per-vector hold, done pulse, results.
   task automatic run_sweep(input int inst, input int settle, input string name);
      int  e_err, e_ones, e_first;
      bit  e_fev, seen;
      int  cnt, hold, prev, hold_bad, busy_bad;
      expect_range(inst, 127, e_err, e_ones, e_first, e_fev);
      start_r[inst] = 1'b1;
      @(posedge clk); #1;
      start_r[inst] = 1'b0;
      tests++;
      if (busy_w[inst] !== 1 || vec_w[inst] !== 0 || err_w[inst] !== 0 || ones_w[inst] !== 0 ||
          fev_w[inst] !== 0 || ferr_w[inst] !== 0 || pass_w[inst] !== 0) begin
         fails++;
         $display("FAIL %s_start: busy=%b vec=%0d err=%0d ones=%0d fev=%b ferr=%0d pass=%b, required busy=1 rest 0",
                  name, busy_w[inst], vec_w[inst], err_w[inst], ones_w[inst], fev_w[inst], ferr_w[inst], pass_w[inst]);
      end
      prev = 0; hold = 1; cnt = 0; seen = 0; hold_bad = 0; busy_bad = 0;
      while (cnt < 4000 && !seen) begin
         @(posedge clk); #1;
         cnt++;
         if (done_w[inst] === 1'b1) begin
            seen = 1;
         end else begin
            if (busy_w[inst] !== 1'b1) busy_bad++;
            if (int'(vec_w[inst]) == prev) hold++;
            else begin
               if (hold != settle + 1 || int'(vec_w[inst]) != prev + 1) hold_bad++;
               prev = int'(vec_w[inst]);
               hold = 1;
            end
         end
      end
      // done is seen in the cycle that begins 128*(SETTLE+1) edges after the start edge
      tests++;
      if (!seen || cnt != 128 * (settle + 1)) begin
         fails++;
         $display("FAIL %s_latency: done after %0d edges (seen=%0d), required %0d", name, cnt, seen, 128 * (settle + 1));
      end
      tests++;
      if (hold_bad != 0 || hold != settle + 1 || prev != 127) begin
         fails++;
         $display("FAIL %s_hold: bad_steps=%0d last_hold=%0d last_vec=%0d, required 0 %0d 127", name, hold_bad, hold, prev, settle + 1);
      end
      tests++;
      if (busy_bad != 0 || busy_w[inst] !== 1'b0) begin
         fails++;
         $display("FAIL %s_busy: low_while_running=%0d busy_at_done=%b, required 0 0", name, busy_bad, busy_w[inst]);
      end
      @(posedge clk); #1;
      tests++;
      if (done_w[inst] !== 0 || busy_w[inst] !== 0 || vec_w[inst] !== 7'd127) begin
         fails++;
         $display("FAIL %s_after_done: done=%b busy=%b vec=%0d, required 0 0 127", name, done_w[inst], busy_w[inst], vec_w[inst]);
      end
      tests++;
      if (int'(err_w[inst]) != e_err || int'(ones_w[inst]) != e_ones || fev_w[inst] !== e_fev ||
          int'(ferr_w[inst]) != (e_fev ? e_first : 0) || pass_w[inst] !== (e_err == 0)) begin
         fails++;
         $display("FAIL %s_results: err=%0d ones=%0d fev=%b ferr=%0d pass=%b, required %0d %0d %0d %0d %0d",
                  name, err_w[inst], ones_w[inst], fev_w[inst], ferr_w[inst], pass_w[inst],
                  e_err, e_ones, e_fev, e_fev ? e_first : 0, e_err == 0);
      end
      $display("[TB] sweep %s: err=%0d ones=%0d ferr=%0d fev=%b pass=%b latency=%0d",
               name, err_w[inst], ones_w[inst], ferr_w[inst], fev_w[inst], pass_w[inst], cnt);
   endtask

   function automatic logic [127:0] fault_mask(input int kind);
      logic [127:0] m;
      for (int i = 0; i < 128; i++) begin
         if (kind == 0) m[i] = 1'b0;
         else if (kind == 1) m[i] = gold(7'(i));       // output stuck at 0
         else m[i] = ~gold(7'(i));                     // output stuck at 1
      end
      return m;
   endfunction

   // Correct, stuck-0, stuck-1 sweeps, run back to back on SETTLE=1.
   task automatic test_back_to_back();
      flip[0] = fault_mask(0); run_sweep(0, 1, "correct");
      flip[0] = fault_mask(1); run_sweep(0, 1, "tied0");
      flip[0] = fault_mask(2); run_sweep(0, 1, "tied1");
      flip[0] = fault_mask(0); run_sweep(0, 1, "correct_again");
   endtask

   task automatic test_settle3();
      flip[1] = fault_mask(0);
      run_sweep(1, 3, "settle3");
   endtask

   task automatic test_random();
      for (int r = 0; r < 4; r++) begin
         int inst;
         inst = r % 2;
         for (int w = 0; w < 4; w++) begin
            flip[inst][w*32 +: 32] = ($urandom_range(0, 3) == 0) ? 32'h0 : ($urandom() & $urandom());
         end
         run_sweep(inst, inst == 0 ? 1 : 3, $sformatf("random%0d", r));
      end
   endtask

   // Abort in the 10th SAMPLE cycle (vector 9), then restart a clean sweep.
   task automatic test_abort();
      int e_err, e_ones, e_first;
      bit e_fev, bad;
      flip[0] = fault_mask(0);
      flip[0][3] = 1'b1;                                // one fault before the abort point
      flip[0][9] = 1'b1;                                // lost: sample of vector 9 is aborted
      expect_range(0, 8, e_err, e_ones, e_first, e_fev);
      start_r[0] = 1'b1;
      @(posedge clk); #1;
      start_r[0] = 1'b0;
      for (int k = 0; k < 19; k++) begin @(posedge clk); #1; end
      tests++;
      if (busy_w[0] !== 1 || vec_w[0] !== 7'd9) begin
         fails++;
         $display("FAIL abort_pre: busy=%b vec=%0d, required 1 9", busy_w[0], vec_w[0]);
      end
      abort_r[0] = 1'b1;
      @(posedge clk); #1;
      abort_r[0] = 1'b0;
      tests++;
      if (busy_w[0] !== 0 || done_w[0] !== 0 || vec_w[0] !== 7'd9 || pass_w[0] !== 0) begin
         fails++;
         $display("FAIL abort_stop: busy=%b done=%b vec=%0d pass=%b, required 0 0 9 0", busy_w[0], done_w[0], vec_w[0], pass_w[0]);
      end
      tests++;
      if (int'(err_w[0]) != e_err || int'(ones_w[0]) != e_ones || fev_w[0] !== e_fev || int'(ferr_w[0]) != e_first) begin
         fails++;
         $display("FAIL abort_partial: err=%0d ones=%0d fev=%b ferr=%0d, required %0d %0d %0d %0d",
                  err_w[0], ones_w[0], fev_w[0], ferr_w[0], e_err, e_ones, e_fev, e_first);
      end
      bad = 0;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         if (done_w[0] !== 0 || busy_w[0] !== 0 || vec_w[0] !== 7'd9 || pass_w[0] !== 0) bad = 1;
      end
      tests++;
      if (bad) begin
         fails++;
         $display("FAIL abort_hold: done=%b busy=%b vec=%0d pass=%b, required 0 0 9 0", done_w[0], busy_w[0], vec_w[0], pass_w[0]);
      end
      $display("[TB] abort at vector 9: err=%0d ones=%0d", err_w[0], ones_w[0]);
      flip[0] = fault_mask(0);
      run_sweep(0, 1, "restart");
   endtask

   // Start pulses while busy are ignored; async reset mid-WAIT clears at once.
   task automatic test_reset_mid();
      int e_err, e_ones, e_first, vec_bad;
      bit e_fev;
      flip[0] = fault_mask(0);
      expect_range(0, 4, e_err, e_ones, e_first, e_fev);
      start_r[0] = 1'b1;
      @(posedge clk); #1;
      start_r[0] = 1'b0;
      vec_bad = 0;
      for (int k = 1; k <= 10; k++) begin
         @(posedge clk); #1;
         start_r[0] = 1'b0;
         if (int'(vec_w[0]) != k / 2 || busy_w[0] !== 1'b1) vec_bad++;
         if (k == 3 || k == 6) start_r[0] = 1'b1;
      end
      start_r[0] = 1'b0;
      tests++;
      if (vec_bad != 0 || int'(ones_w[0]) != e_ones) begin
         fails++;
         $display("FAIL start_ignored: bad_cycles=%0d ones=%0d, required 0 %0d", vec_bad, ones_w[0], e_ones);
      end
      #2 rst_n = 1'b0;
      #1;
      tests++;
      if (vec_w[0] !== 0 || busy_w[0] !== 0 || done_w[0] !== 0 || pass_w[0] !== 0 ||
          err_w[0] !== 0 || ferr_w[0] !== 0 || fev_w[0] !== 0 || ones_w[0] !== 0) begin
         fails++;
         $display("FAIL async_reset: vec=%0d busy=%b done=%b pass=%b err=%0d ferr=%0d fev=%b ones=%0d, all required 0",
                  vec_w[0], busy_w[0], done_w[0], pass_w[0], err_w[0], ferr_w[0], fev_w[0], ones_w[0]);
      end
      $display("[TB] async reset mid-sweep: vec=%0d busy=%b ones=%0d", vec_w[0], busy_w[0], ones_w[0]);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   initial begin
      rst_n = 1'b0;
      for (int k = 0; k < 2; k++) begin
         start_r[k] = 1'b0; abort_r[k] = 1'b0; flip[k] = '0;
      end
      repeat (3) @(posedge clk);
      #1;
      test_reset();
      test_back_to_back();
      test_settle3();
      test_random();
      test_abort();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
